cswap_unit: RTL and testbench

- Registered, parameterised Fredkin (controlled-swap) gate array.
- Each bit lane i passes control bit a[i] through unchanged and swaps b[i]/c[i] when a[i]=1, otherwise passes them straight.
- Used as a reversible-logic primitive inside datapaths: sorters, conditional exchange networks, reversible-logic experiments.
- Outputs are pipelined by STAGES registers, with a valid flag travelling alongside.

---
 rtl/cswap_unit_if.sv | 32 +++
 rtl/cswap_unit.sv | 111 +++++++++++
 tb/tb_cswap_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cswap_unit_if.sv
// Bus bundle for the controlled-swap (Fredkin) lane array.
// Carries the operand/valid inputs and the pipelined results.
// The optional ones-count monitor ports exist only when CSWAP_ONES_CHECK_EN is defined.
interface cswap_unit_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] c1;
    logic             out_valid;
`ifdef CSWAP_ONES_CHECK_EN
    localparam int CNT_W = $clog2(3 * WIDTH + 1);
    logic [CNT_W-1:0] ones_cnt;
    logic             cons_err;
`endif

`ifdef CSWAP_ONES_CHECK_EN
    modport master (output in_valid, a, b, c,
                    input  a1, b1, c1, out_valid, ones_cnt, cons_err);
    modport slave  (input  in_valid, a, b, c,
                    output a1, b1, c1, out_valid, ones_cnt, cons_err);
`else
    modport master (output in_valid, a, b, c,
                    input  a1, b1, c1, out_valid);
    modport slave  (input  in_valid, a, b, c,
                    output a1, b1, c1, out_valid);
`endif
endinterface

// File: rtl/cswap_unit.sv
// Registered, parameterised Fredkin (controlled-swap) gate array.
// Lane i passes a[i] through and exchanges b[i]/c[i] when a[i]=1.
// Results travel through STAGES registers with a valid flag alongside;
// data registers load every cycle, only the valid flag qualifies them.
// Optional feature macro: CSWAP_ONES_CHECK_EN adds a ones-count output and
// a sticky conservation-error flag comparing output vs input popcount.
module cswap_unit #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    cswap_unit_if.slave   bus
);

    // Swap network: pure combinational per-lane exchange.
    logic [WIDTH-1:0] swap_b_s;
    logic [WIDTH-1:0] swap_c_s;

    assign swap_b_s = (bus.a & bus.c) | (~bus.a & bus.b);
    assign swap_c_s = (bus.a & bus.b) | (~bus.a & bus.c);

    logic [WIDTH-1:0] a_pipe_r [STAGES];
    logic [WIDTH-1:0] b_pipe_r [STAGES];
    logic [WIDTH-1:0] c_pipe_r [STAGES];
    logic [STAGES-1:0] vld_pipe_r;

    // Result pipeline: stage 0 captures the swap result, later stages shift it along.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                a_pipe_r[s]   <= {WIDTH{1'b0}};
                b_pipe_r[s]   <= {WIDTH{1'b0}};
                c_pipe_r[s]   <= {WIDTH{1'b0}};
                vld_pipe_r[s] <= 1'b0;
            end
        end else begin
            a_pipe_r[0]   <= bus.a;
            b_pipe_r[0]   <= swap_b_s;
            c_pipe_r[0]   <= swap_c_s;
            vld_pipe_r[0] <= bus.in_valid;
            for (int s = 1; s < STAGES; s++) begin
                a_pipe_r[s]   <= a_pipe_r[s-1];
                b_pipe_r[s]   <= b_pipe_r[s-1];
                c_pipe_r[s]   <= c_pipe_r[s-1];
                vld_pipe_r[s] <= vld_pipe_r[s-1];
            end
        end
    end

    assign bus.a1        = a_pipe_r[STAGES-1];
    assign bus.b1        = b_pipe_r[STAGES-1];
    assign bus.c1        = c_pipe_r[STAGES-1];
    assign bus.out_valid = vld_pipe_r[STAGES-1];

`ifdef CSWAP_ONES_CHECK_EN
    localparam int CNT_W = $clog2(3 * WIDTH + 1);

    // Population count of one operand, widened to the full three-operand count width.
    function automatic logic [CNT_W-1:0] pop_cnt(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [CNT_W-1:0] in_cnt_s;
    logic [CNT_W-1:0] out_cnt_s;
    logic [CNT_W-1:0] in_cnt_r  [STAGES];
    logic [CNT_W-1:0] out_cnt_r [STAGES];
    logic             cons_err_r;

    assign in_cnt_s  = pop_cnt(bus.a) + pop_cnt(bus.b) + pop_cnt(bus.c);
    assign out_cnt_s = pop_cnt(bus.a) + pop_cnt(swap_b_s) + pop_cnt(swap_c_s);

    // Count pipelines: input and output popcounts ride alongside the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                in_cnt_r[s]  <= {CNT_W{1'b0}};
                out_cnt_r[s] <= {CNT_W{1'b0}};
            end
        end else begin
            in_cnt_r[0]  <= in_cnt_s;
            out_cnt_r[0] <= out_cnt_s;
            for (int s = 1; s < STAGES; s++) begin
                in_cnt_r[s]  <= in_cnt_r[s-1];
                out_cnt_r[s] <= out_cnt_r[s-1];
            end
        end
    end

    // Sticky conservation flag: latches when a valid result's count disagrees with its input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cons_err_r <= 1'b0;
        end else if (vld_pipe_r[STAGES-1] &&
                     (out_cnt_r[STAGES-1] != in_cnt_r[STAGES-1])) begin
            cons_err_r <= 1'b1;
        end else begin
            cons_err_r <= cons_err_r;
        end
    end

    assign bus.ones_cnt = out_cnt_r[STAGES-1];
    assign bus.cons_err = cons_err_r;
`endif

endmodule

// File: tb/tb_cswap_unit.sv
// Directed self-checking bench for cswap_unit: truth table, lane independence,
// latency, self-inverse chain, and asynchronous reset mid-stream.
module tb_cswap_unit;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    cswap_unit_if #(.WIDTH(1)) if1 ();
    cswap_unit_if #(.WIDTH(8)) if8 ();
    cswap_unit_if #(.WIDTH(4)) if3 ();
    cswap_unit_if #(.WIDTH(8)) if2 ();
    cswap_unit_if #(.WIDTH(8)) ifc ();

    cswap_unit #(.WIDTH(1), .STAGES(1)) u_w1 (.clk(clk), .rst(rst), .bus(if1));
    cswap_unit #(.WIDTH(8), .STAGES(1)) u_w8 (.clk(clk), .rst(rst), .bus(if8));
    cswap_unit #(.WIDTH(4), .STAGES(3)) u_s3 (.clk(clk), .rst(rst), .bus(if3));
    cswap_unit #(.WIDTH(8), .STAGES(2)) u_s2 (.clk(clk), .rst(rst), .bus(if2));
    cswap_unit #(.WIDTH(8), .STAGES(2)) u_ch (.clk(clk), .rst(rst), .bus(ifc));

    // Second chain element takes the first one's outputs.
    assign ifc.in_valid = if2.out_valid;
    assign ifc.a        = if2.a1;
    assign ifc.b        = if2.b1;
    assign ifc.c        = if2.c1;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  tt [8];
    logic [24:0] hist [1000];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // Hand-derived Fredkin truth table indexed by {a,b,c}.
        tt[0] = 3'b000; tt[1] = 3'b001; tt[2] = 3'b010; tt[3] = 3'b011;
        tt[4] = 3'b100; tt[5] = 3'b110; tt[6] = 3'b101; tt[7] = 3'b111;

        rst = 1'b1;
        if1.in_valid = 1'b0; if1.a = 1'b0;  if1.b = 1'b0;  if1.c = 1'b0;
        if8.in_valid = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.c = 8'h00;
        if3.in_valid = 1'b0; if3.a = 4'h0;  if3.b = 4'h0;  if3.c = 4'h0;
        if2.in_valid = 1'b0; if2.a = 8'h00; if2.b = 8'h00; if2.c = 8'h00;

        // Reset state, before any clock edge (asynchronous clear).
        #2;
        check_eq("rst_w1", {29'd0, if1.a1, if1.b1, if1.c1}, 32'd0);
        check_eq("rst_w1_vld", {31'd0, if1.out_valid}, 32'd0);
        check_eq("rst_s3_vld", {31'd0, if3.out_valid}, 32'd0);
        check_eq("rst_s2", {8'd0, if2.a1, if2.b1, if2.c1}, 32'd0);
`ifdef CSWAP_ONES_CHECK_EN
        check_eq("rst_ones", 32'(if2.ones_cnt), 32'd0);
        check_eq("rst_cerr", {31'd0, if2.cons_err}, 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;

        // Exhaustive single-lane truth table, one vector per cycle.
        for (int v = 0; v < 8; v++) begin
            if1.in_valid = 1'b1;
            {if1.a, if1.b, if1.c} = 3'(v);
            tick();
            check_eq($sformatf("tt_%0d", v), {29'd0, if1.a1, if1.b1, if1.c1}, {29'd0, tt[v]});
            check_eq($sformatf("tt_vld_%0d", v), {31'd0, if1.out_valid}, 32'd1);
        end
        if1.in_valid = 1'b0;
        tick();
        check_eq("tt_vld_drop", {31'd0, if1.out_valid}, 32'd0);

        // Lane independence on an 8-lane instance.
        if8.in_valid = 1'b1; if8.a = 8'hF0; if8.b = 8'hAA; if8.c = 8'h55;
        tick();
        check_eq("lane_a1", {24'd0, if8.a1}, 32'h0000_00F0);
        check_eq("lane_b1", {24'd0, if8.b1}, 32'h0000_005A);
        check_eq("lane_c1", {24'd0, if8.c1}, 32'h0000_00A5);
        check_eq("lane_vld", {31'd0, if8.out_valid}, 32'd1);
        if8.in_valid = 1'b0;

        // Latency with STAGES=3: single valid pulse appears on the third edge only.
        if3.in_valid = 1'b1; if3.a = 4'h1; if3.b = 4'h1; if3.c = 4'h0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 1) begin
                if3.in_valid = 1'b0; if3.a = 4'h0; if3.b = 4'h0; if3.c = 4'h0;
            end
            check_eq($sformatf("lat_vld_e%0d", e), {31'd0, if3.out_valid}, (e == 3) ? 32'd1 : 32'd0);
            if (e == 3) begin
                check_eq("lat_a1", {28'd0, if3.a1}, 32'h1);
                check_eq("lat_b1", {28'd0, if3.b1}, 32'h0);
                check_eq("lat_c1", {28'd0, if3.c1}, 32'h1);
            end
        end

        // Self-inverse chain: two 2-stage instances back to back return the inputs 4 edges later.
        for (int n = 0; n < 1000; n++) begin
            if2.in_valid = ($urandom_range(0, 3) != 0);
            if2.a = 8'($urandom());
            if2.b = 8'($urandom());
            if2.c = 8'($urandom());
            hist[n] = {if2.in_valid, if2.a, if2.b, if2.c};
            tick();
            if (n >= 1) begin
                check_eq("s2_vld", {31'd0, if2.out_valid}, {31'd0, hist[n-1][24]});
                if (hist[n-1][24]) begin
                    check_eq("pop_cons", $countones({if2.a1, if2.b1, if2.c1}),
                             $countones(hist[n-1][23:0]));
                end
`ifdef CSWAP_ONES_CHECK_EN
                check_eq("ones_cnt", 32'(if2.ones_cnt), $countones(hist[n-1][23:0]));
                check_eq("cons_err", {31'd0, if2.cons_err}, 32'd0);
`endif
            end
            if (n >= 3) begin
                check_eq("inverse", {7'd0, ifc.out_valid, ifc.a1, ifc.b1, ifc.c1}, {7'd0, hist[n-3]});
            end
        end

        // Asynchronous reset while a valid operation is in flight.
        if2.in_valid = 1'b1; if2.a = 8'hFF; if2.b = 8'h0F; if2.c = 8'hF0;
        tick();
        if2.in_valid = 1'b0; if2.a = 8'h00; if2.b = 8'h00; if2.c = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_data", {8'd0, if2.a1, if2.b1, if2.c1}, 32'd0);
        check_eq("arst_vld", {31'd0, if2.out_valid}, 32'd0);
        tick();
        check_eq("arst_hold_vld", {31'd0, if2.out_valid}, 32'd0);
        #3;
        rst = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            check_eq($sformatf("post_rst_vld_%0d", e), {31'd0, if2.out_valid}, 32'd0);
            check_eq($sformatf("post_rst_b1_%0d", e), {24'd0, if2.b1}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
